// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// frame geometry and default timing derived from the system clock.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_RELEASE  = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAITIDLE = 3'd5
    } state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;
    localparam int SHIFT_W    = FRAME_BITS - 2;
    localparam int CNT_W      = 20;

    // bitcnt value at which the stop slot is reached (data released)
    localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 2);

    localparam int CLK_HZ                 = 50_000_000;
    localparam int INHIBIT_CYCLES_DEFAULT = CLK_HZ / 10_000;      // 100 us
    localparam int TIMEOUT_CYCLES_DEFAULT = (CLK_HZ / 1000) * 15; // 15 ms

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Three-flop synchroniser for one PS/2 pad with a falling-edge detector.
// Flops reset to 1 so a released (pulled-up) bus never looks like an edge.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic fall
);

    logic [2:0] s;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, exactly like hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= '1;
        end else begin
            s <= {s[1:0], pad};
        end
    end

    assign level = s[1];
    assign fall  = s[2] & ~s[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends start/data/parity/
// stop on device clock edges, checks the device ack, guarded by a watchdog.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [3:0]           bitcnt, bitcnt_next;
    logic [SHIFT_W-1:0]   shift, shift_next;
    logic                 ack_ok, ack_ok_next;
    logic                 clk_dl_next, data_dl_next;
    logic                 done_next, ack_err_next, timeout_err_next;

    logic clk_level, clk_fall;
    logic data_level, unused_data_fall;

    ps2_sync_edge u_sync_clk (
        .clk   (clk),
        .rst   (rst),
        .pad   (ps2_clk_i),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_sync_data (
        .clk   (clk),
        .rst   (rst),
        .pad   (ps2_data_i),
        .level (data_level),
        .fall  (unused_data_fall)
    );

    assign tx_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        bitcnt_next      = bitcnt;
        shift_next       = shift;
        ack_ok_next      = ack_ok;
        clk_dl_next      = ps2_clk_drive_low;
        data_dl_next     = ps2_data_drive_low;
        done_next        = 1'b0;
        ack_err_next     = 1'b0;
        timeout_err_next = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_next   = ST_INHIBIT;
                    cnt_next     = INHIBIT_LOAD;
                    shift_next   = {odd_parity(tx_data), tx_data};
                    clk_dl_next  = 1'b1;
                    data_dl_next = 1'b0;
                end
            end

            ST_INHIBIT: begin
                // Start bit goes low on the same edge the clock is let go.
                if (cnt == '0) begin
                    state_next   = ST_RELEASE;
                    clk_dl_next  = 1'b0;
                    data_dl_next = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            ST_RELEASE: begin
                state_next  = ST_SHIFT;
                cnt_next    = TIMEOUT_LOAD;
                bitcnt_next = '0;
            end

            ST_SHIFT: begin
                if (clk_fall) begin
                    cnt_next     = TIMEOUT_LOAD;
                    bitcnt_next  = bitcnt + 1'b1;
                    data_dl_next = (bitcnt == STOP_IDX) ? 1'b0 : ~shift[bitcnt];
                    if (bitcnt == STOP_IDX) begin
                        state_next = ST_ACK;
                    end
                end else if (cnt == '0) begin
                    state_next       = ST_IDLE;
                    clk_dl_next      = 1'b0;
                    data_dl_next     = 1'b0;
                    timeout_err_next = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            ST_ACK: begin
                if (clk_fall) begin
                    cnt_next    = TIMEOUT_LOAD;
                    ack_ok_next = ~data_level;
                    state_next  = ST_WAITIDLE;
                end else if (cnt == '0) begin
                    state_next       = ST_IDLE;
                    clk_dl_next      = 1'b0;
                    data_dl_next     = 1'b0;
                    timeout_err_next = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            ST_WAITIDLE: begin
                if (clk_level && data_level) begin
                    state_next   = ST_IDLE;
                    done_next    = ack_ok;
                    ack_err_next = ~ack_ok;
                end else if (clk_fall) begin
                    cnt_next = TIMEOUT_LOAD;
                end else if (cnt == '0) begin
                    state_next       = ST_IDLE;
                    clk_dl_next      = 1'b0;
                    data_dl_next     = 1'b0;
                    timeout_err_next = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            default: begin
                state_next   = ST_IDLE;
                clk_dl_next  = 1'b0;
                data_dl_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            bitcnt             <= '0;
            shift              <= '0;
            ack_ok             <= 1'b0;
            ps2_clk_drive_low  <= 1'b0;
            ps2_data_drive_low <= 1'b0;
            done               <= 1'b0;
            ack_err            <= 1'b0;
            timeout_err        <= 1'b0;
        end else begin
            state              <= state_next;
            cnt                <= cnt_next;
            bitcnt             <= bitcnt_next;
            shift              <= shift_next;
            ack_ok             <= ack_ok_next;
            ps2_clk_drive_low  <= clk_dl_next;
            ps2_data_drive_low <= data_dl_next;
            done               <= done_next;
            ack_err            <= ack_err_next;
            timeout_err        <= timeout_err_next;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device BFM clocks frames at one edge per 100 clk
// and results are compared with a frame model built from the PS/2 framing rules.
module tb_ps2_host_tx;

    localparam int INHIBIT  = 20;
    localparam int TIMEOUT  = 2000;
    localparam int HALF     = 50;
    localparam int SYNC_LAT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, done, ack_err, timeout_err;
    logic       ps2_clk_i, ps2_data_i;
    logic       ps2_clk_drive_low, ps2_data_drive_low;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    // open-drain bus with pull-ups
    assign ps2_clk_i  = ~(ps2_clk_drive_low | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_drive_low | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_valid           (tx_valid),
        .tx_data            (tx_data),
        .tx_ready           (tx_ready),
        .busy               (busy),
        .done               (done),
        .ack_err            (ack_err),
        .timeout_err        (timeout_err),
        .ps2_clk_i          (ps2_clk_i),
        .ps2_data_i         (ps2_data_i),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int n_done = 0, n_ack_err = 0, n_tmo = 0, n_wide = 0, n_multi = 0, n_accept = 0;
    logic prev_done = 1'b0, prev_ack = 1'b0, prev_tmo = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_valid && tx_ready) n_accept <= n_accept + 1;
    end

    always @(negedge clk) begin
        if (done)        n_done    <= n_done + 1;
        if (ack_err)     n_ack_err <= n_ack_err + 1;
        if (timeout_err) n_tmo     <= n_tmo + 1;
        if ((done && prev_done) || (ack_err && prev_ack) || (timeout_err && prev_tmo))
            n_wide <= n_wide + 1;
        if (int'(done) + int'(ack_err) + int'(timeout_err) > 1)
            n_multi <= n_multi + 1;
        prev_done <= done;
        prev_ack  <= ack_err;
        prev_tmo  <= timeout_err;
    end

    // Bits as the device sees them just before each falling clock:
    // [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic device_rx(input int n_edges, input bit do_ack,
                             output logic [10:0] bits, output int hold);
        int t = 0;
        bits = '1;
        hold = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ps2_clk_drive_low && t < 400);
        if (!ps2_clk_drive_low) begin
            checks++; failures++;
            $display("FAIL inhibit_start: clk_drive_low=%b after %0d cycles, required 1", ps2_clk_drive_low, t);
            return;
        end
        while (ps2_clk_drive_low && hold < 10000) begin
            @(negedge clk);
            hold++;
        end
        checks++;
        if (ps2_data_drive_low !== 1'b1) begin
            failures++;
            $display("FAIL start_bit_at_release: data_drive_low=%b, required 1", ps2_data_drive_low);
        end
        for (int e = 1; e <= n_edges; e++) begin
            repeat (HALF) @(posedge clk);
            #1;
            bits[e-1] = ps2_data_i;
            if (e == 11 && do_ack) begin
                dev_data_low = 1'b1;
                repeat (HALF / 2) @(posedge clk);
                #1;
            end
            dev_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            repeat (HALF) @(posedge clk);
            #1;
            dev_clk_low = 1'b0;
        end
        if (n_edges >= 11) begin
            repeat (20) @(posedge clk);
            #1;
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!tx_ready && t < 1000);
        checks++;
        if (!tx_ready) begin
            failures++;
            $display("FAIL %s idle_wait: tx_ready=%b after %0d cycles, required 1", tag, tx_ready, t);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, input string tag);
        logic [10:0] bits, expv;
        int hold, d0, a0, c0;
        d0 = n_done; a0 = n_ack_err; c0 = n_accept;
        fork
            send_byte(b);
            device_rx(11, ack, bits, hold);
        join
        wait_idle(tag);
        expv = frame_model(b);
        checks++;
        if (bits !== expv) begin
            failures++;
            $display("FAIL %s frame 0x%02h: got %b required %b", tag, b, bits, expv);
        end
        checks++;
        if (hold != INHIBIT) begin
            failures++;
            $display("FAIL %s inhibit_len: got %0d required %0d", tag, hold, INHIBIT);
        end
        checks++;
        if (n_done - d0 != (ack ? 1 : 0) || n_ack_err - a0 != (ack ? 0 : 1)) begin
            failures++;
            $display("FAIL %s status: done=%0d ack_err=%0d required done=%0d ack_err=%0d",
                     tag, n_done - d0, n_ack_err - a0, ack ? 1 : 0, ack ? 0 : 1);
        end
        checks++;
        if (n_accept - c0 != 1) begin
            failures++;
            $display("FAIL %s accepts: got %0d required 1", tag, n_accept - c0);
        end
        checks++;
        if (ps2_clk_drive_low !== 1'b0 || ps2_data_drive_low !== 1'b0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_lines: clk_dl=%b data_dl=%b tx_ready=%b required 0 0 1",
                     tag, ps2_clk_drive_low, ps2_data_drive_low, tx_ready);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({ps2_clk_drive_low, ps2_data_drive_low, done, ack_err, timeout_err, busy, tx_ready} !== 7'b0000001) begin
            failures++;
            $display("FAIL reset_state: got %b required 0000001",
                     {ps2_clk_drive_low, ps2_data_drive_low, done, ack_err, timeout_err, busy, tx_ready});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: tx_ready=%b busy=%b required 1 0", tx_ready, busy);
        end
    endtask

    task automatic test_ed_ack();
        run_frame(8'hED, 1'b1, "ed_ack");
    endtask

    task automatic test_parity_edges();
        run_frame(8'h00, 1'b1, "byte_00");
        run_frame(8'hFF, 1'b1, "byte_ff");
    endtask

    task automatic test_nak();
        run_frame(8'($urandom), 1'b0, "nak");
    endtask

    task automatic test_timeout();
        logic [10:0] bits;
        int hold, t0, d0, a0, lat;
        int t = 0;
        t0 = n_tmo; d0 = n_done; a0 = n_ack_err;
        fork
            send_byte(8'($urandom));
            device_rx(5, 1'b0, bits, hold);
        join
        do begin
            @(negedge clk);
            t++;
        end while (!timeout_err && t < TIMEOUT + 500);
        lat = cyc - last_fall_cyc;
        checks++;
        if (!timeout_err) begin
            failures++;
            $display("FAIL timeout_seen: timeout_err=%b after %0d cycles, required 1", timeout_err, t);
        end else begin
            checks++;
            if (lat != SYNC_LAT + TIMEOUT) begin
                failures++;
                $display("FAIL timeout_latency: got %0d required %0d", lat, SYNC_LAT + TIMEOUT);
            end
            checks++;
            if (ps2_clk_drive_low !== 1'b0 || ps2_data_drive_low !== 1'b0 || tx_ready !== 1'b1) begin
                failures++;
                $display("FAIL timeout_release: clk_dl=%b data_dl=%b tx_ready=%b required 0 0 1",
                         ps2_clk_drive_low, ps2_data_drive_low, tx_ready);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n_tmo - t0 != 1 || n_done != d0 || n_ack_err != a0) begin
            failures++;
            $display("FAIL timeout_pulses: tmo=%0d done=%0d ack_err=%0d required 1 0 0",
                     n_tmo - t0, n_done - d0, n_ack_err - a0);
        end
        run_frame(8'($urandom), 1'b1, "after_timeout");
    endtask

    task automatic test_reset_midframe();
        logic [10:0] bits;
        int hold, d0, a0, t0;
        fork
            send_byte(8'h00);
            device_rx(4, 1'b0, bits, hold);
        join
        checks++;
        if (ps2_data_drive_low !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midframe_drive: data_dl=%b busy=%b required 1 1", ps2_data_drive_low, busy);
        end
        d0 = n_done; a0 = n_ack_err; t0 = n_tmo;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ps2_clk_drive_low !== 1'b0 || ps2_data_drive_low !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: clk_dl=%b data_dl=%b tx_ready=%b busy=%b required 0 0 1 0",
                     ps2_clk_drive_low, ps2_data_drive_low, tx_ready, busy);
        end
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (TIMEOUT + 100) @(negedge clk);
        checks++;
        if (n_done != d0 || n_ack_err != a0 || n_tmo != t0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_no_pulse: done=%0d ack_err=%0d tmo=%0d tx_ready=%b required 0 0 0 1",
                     n_done - d0, n_ack_err - a0, n_tmo - t0, tx_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        logic [10:0] bits_a, bits_b;
        int hold_a, hold_b, d0, c0;
        a = 8'($urandom);
        b = 8'($urandom);
        d0 = n_done; c0 = n_accept;
        fork
            begin
                int t = 0;
                @(negedge clk);
                tx_valid = 1'b1;
                tx_data  = a;
                @(posedge clk);
                #1;
                tx_data = b;
                do begin
                    @(negedge clk);
                    t++;
                end while (!tx_ready && t < 3000);
                @(posedge clk);
                #1;
                tx_valid = 1'b0;
            end
            begin
                device_rx(11, 1'b1, bits_a, hold_a);
                device_rx(11, 1'b1, bits_b, hold_b);
            end
        join
        wait_idle("b2b");
        checks++;
        if (bits_a !== frame_model(a) || bits_b !== frame_model(b)) begin
            failures++;
            $display("FAIL b2b_frames: got %b %b required %b %b", bits_a, bits_b, frame_model(a), frame_model(b));
        end
        checks++;
        if (n_accept - c0 != 2 || n_done - d0 != 2) begin
            failures++;
            $display("FAIL b2b_counts: accepts=%0d done=%0d required 2 2", n_accept - c0, n_done - d0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(1, 40)) @(negedge clk);
            run_frame(8'($urandom), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_pulse_integrity();
        checks++;
        if (n_wide != 0 || n_multi != 0) begin
            failures++;
            $display("FAIL pulse_integrity: wide=%0d overlapping=%0d required 0 0", n_wide, n_multi);
        end
    endtask

    initial begin
        test_reset();
        test_ed_ack();
        test_parity_edges();
        test_nak();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        test_pulse_integrity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "global timeout");
    end

endmodule
